// File: rtl/flow_cond_writer_pkg.sv
// Shared register-map constants for the detect_flow condition file, plus the
// helper that slices a 96-bit match condition into its four register words.
package flow_cond_writer_pkg;

  localparam int COND_WIDTH    = 96;
  localparam int REGS_PER_FLOW = 4;

  localparam int SRC_IP   = 0;
  localparam int SRC_PORT = 1;
  localparam int DST_IP   = 2;
  localparam int DST_PORT = 3;

  localparam int SRC_IP_LSB   = 64;
  localparam int SRC_PORT_LSB = 48;
  localparam int DST_IP_LSB   = 16;
  localparam int DST_PORT_LSB = 0;
  localparam int IP_BITS      = 32;
  localparam int PORT_BITS    = 16;

  typedef enum logic [1:0] {CTL_IDLE, CTL_WRITE, CTL_DONE} ctl_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;

  // Ports are zero-extended so every register holds a full 32-bit word.
  function automatic logic [31:0] cond_word(input logic [COND_WIDTH-1:0] cond,
                                            input logic [1:0] k);
    logic [31:0] word;
    case (int'(k))
      SRC_IP:   word = cond[SRC_IP_LSB +: IP_BITS];
      SRC_PORT: word = {16'd0, cond[SRC_PORT_LSB +: PORT_BITS]};
      DST_IP:   word = cond[DST_IP_LSB +: IP_BITS];
      DST_PORT: word = {16'd0, cond[DST_PORT_LSB +: PORT_BITS]};
      default:  word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/axil_single_write.sv
// One AXI4-Lite write: AW and W launched together, each retired on its own
// READY, then a single B beat. A start on the B beat chains the next write.
module axil_single_write
  import flow_cond_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  wr_state_t               state_reg;
  logic                    awvalid_reg, wvalid_reg, bready_reg;
  logic [ADDR_WIDTH-1:0]   awaddr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [DATA_WIDTH/8-1:0] wstrb_reg;
  logic                    aw_ok, w_ok;

  // A channel is finished if it already retired or retires this cycle.
  assign aw_ok = !awvalid_reg || awready;
  assign w_ok  = !wvalid_reg || wready;
  assign done  = bready_reg && bvalid;
  assign error = done && (bresp != 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= WR_IDLE;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      case (state_reg)
        WR_IDLE: begin
          if (start) begin
            state_reg   <= WR_ADDR;
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
            awaddr_reg  <= addr;
            wdata_reg   <= data;
            wstrb_reg   <= '1;
          end
        end
        WR_ADDR: begin
          if (awready) awvalid_reg <= 1'b0;
          if (wready)  wvalid_reg  <= 1'b0;
          if (aw_ok && w_ok) begin
            state_reg  <= WR_RESP;
            bready_reg <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_reg <= 1'b0;
            if (start) begin
              state_reg   <= WR_ADDR;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              awaddr_reg  <= addr;
              wdata_reg   <= data;
              wstrb_reg   <= '1;
            end else begin
              state_reg <= WR_IDLE;
            end
          end
        end
        default: state_reg <= WR_IDLE;
      endcase
    end
  end

  assign awaddr  = awaddr_reg;
  assign awvalid = awvalid_reg;
  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wvalid  = wvalid_reg;
  assign bready  = bready_reg;

endmodule

// File: rtl/flow_cond_writer.sv
// Turns {flow_id, cond} commands into four AXI4-Lite register writes into the
// detect_flow condition file; the ADDR/RESP phases live in axil_single_write.
module flow_cond_writer
  import flow_cond_writer_pkg::*;
#(
  parameter int FLOW_NUM           = 16,
  parameter int FLOW_WIDTH         = 8,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_OF_REGISTERS   = 60,
  parameter int C_M_AXI_ADDR_WIDTH = $clog2(NUM_OF_REGISTERS*(C_M_AXI_DATA_WIDTH/8))
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [FLOW_WIDTH+COND_WIDTH-1:0] s_axis_cmd_tdata,
  input  logic                            s_axis_cmd_tvalid,
  output logic                            s_axis_cmd_tready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic                            resp_valid,
  output logic                            resp_error,
  output logic                            busy
);

  localparam int ADDR_LSB = $clog2(C_M_AXI_DATA_WIDTH/8);

  ctl_state_t              state_reg;
  logic                    tready_reg, busy_reg, resp_valid_reg, resp_error_reg, err_reg;
  logic [FLOW_WIDTH-1:0]   flow_id_reg;
  logic [COND_WIDTH-1:0]   cond_reg;
  logic [1:0]              k_reg;

  logic [FLOW_WIDTH-1:0]   cmd_id, id_src;
  logic [COND_WIDTH-1:0]   cmd_cond, cond_src;
  logic                    cmd_hs, cmd_id_ok, wr_start, wr_done, wr_error;
  logic [1:0]              k_src;
  logic [31:0]             word_mux [REGS_PER_FLOW];
  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0] start_data;

  assign cmd_id    = s_axis_cmd_tdata[FLOW_WIDTH+COND_WIDTH-1 -: FLOW_WIDTH];
  assign cmd_cond  = s_axis_cmd_tdata[COND_WIDTH-1:0];
  assign cmd_hs    = s_axis_cmd_tvalid && tready_reg;
  assign cmd_id_ok = (cmd_id != '0) && (int'(cmd_id) < FLOW_NUM);

  // The first word is launched straight from the command bus on the accept
  // edge; later words come from the latched copy with k advanced by one.
  always_comb begin
    wr_start = 1'b0;
    id_src   = flow_id_reg;
    cond_src = cond_reg;
    k_src    = k_reg + 2'd1;
    if (state_reg == CTL_IDLE) begin
      id_src   = cmd_id;
      cond_src = cmd_cond;
      k_src    = 2'd0;
      wr_start = cmd_hs && cmd_id_ok;
    end else if (state_reg == CTL_WRITE) begin
      wr_start = wr_done && (k_reg != 2'd3);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < REGS_PER_FLOW; gi++) begin : g_word
      assign word_mux[gi] = cond_word(cond_src, 2'(gi));
    end
  endgenerate

  assign start_data = C_M_AXI_DATA_WIDTH'(word_mux[k_src]);
  assign start_addr = C_M_AXI_ADDR_WIDTH'(((32'(id_src) - 32'd1) * 32'(REGS_PER_FLOW)
                                          + 32'(k_src)) << ADDR_LSB);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= CTL_IDLE;
      tready_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_error_reg <= 1'b0;
      err_reg        <= 1'b0;
      flow_id_reg    <= '0;
      cond_reg       <= '0;
      k_reg          <= 2'd0;
    end else begin
      case (state_reg)
        CTL_IDLE: begin
          tready_reg <= 1'b1;
          if (cmd_hs) begin
            tready_reg  <= 1'b0;
            flow_id_reg <= cmd_id;
            cond_reg    <= cmd_cond;
            k_reg       <= 2'd0;
            err_reg     <= 1'b0;
            if (cmd_id_ok) begin
              state_reg <= CTL_WRITE;
              busy_reg  <= 1'b1;
            end else begin
              state_reg      <= CTL_DONE;
              resp_valid_reg <= 1'b1;
              resp_error_reg <= 1'b1;
            end
          end
        end
        CTL_WRITE: begin
          // A bad BRESP is remembered but the remaining words still go out.
          if (wr_done) begin
            if (wr_error) err_reg <= 1'b1;
            if (k_reg == 2'd3) begin
              state_reg      <= CTL_DONE;
              busy_reg       <= 1'b0;
              resp_valid_reg <= 1'b1;
              resp_error_reg <= err_reg || wr_error;
            end else begin
              k_reg <= k_reg + 2'd1;
            end
          end
        end
        CTL_DONE: begin
          resp_valid_reg <= 1'b0;
          resp_error_reg <= 1'b0;
          tready_reg     <= 1'b1;
          state_reg      <= CTL_IDLE;
        end
        default: state_reg <= CTL_IDLE;
      endcase
    end
  end

  axil_single_write #(
    .ADDR_WIDTH (C_M_AXI_ADDR_WIDTH),
    .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
  ) u_wr (
    .clk     (clk),
    .rstn    (rstn),
    .start   (wr_start),
    .addr    (start_addr),
    .data    (start_data),
    .done    (wr_done),
    .error   (wr_error),
    .awaddr  (M_AXI_AWADDR),
    .awvalid (M_AXI_AWVALID),
    .awready (M_AXI_AWREADY),
    .wdata   (M_AXI_WDATA),
    .wstrb   (M_AXI_WSTRB),
    .wvalid  (M_AXI_WVALID),
    .wready  (M_AXI_WREADY),
    .bresp   (M_AXI_BRESP),
    .bvalid  (M_AXI_BVALID),
    .bready  (M_AXI_BREADY)
  );

  assign s_axis_cmd_tready = tready_reg;
  assign M_AXI_AWPROT      = 3'b000;
  assign resp_valid        = resp_valid_reg;
  assign resp_error        = resp_error_reg;
  assign busy              = busy_reg;

endmodule

// File: tb/tb_flow_cond_writer.sv
// Directed and randomized commands against a programmable-latency AXI4-Lite
// slave; written words are compared with a register-map model of the command.
module tb_flow_cond_writer;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [103:0] tdata = '0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [7:0]   M_AXI_AWADDR;
  logic [2:0]   M_AXI_AWPROT;
  logic         M_AXI_AWVALID;
  logic         awready = 1'b0;
  logic [31:0]  M_AXI_WDATA;
  logic [3:0]   M_AXI_WSTRB;
  logic         M_AXI_WVALID;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         M_AXI_BREADY;
  logic         resp_valid, resp_error, busy;

  flow_cond_writer dut (
    .clk (clk), .rstn (rstn),
    .s_axis_cmd_tdata (tdata), .s_axis_cmd_tvalid (tvalid), .s_axis_cmd_tready (tready),
    .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID), .M_AXI_AWREADY (awready),
    .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (wready),
    .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (M_AXI_BREADY),
    .resp_valid (resp_valid), .resp_error (resp_error), .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: register index (id-1)*4+k, byte address = index*4.
  function automatic logic [7:0] exp_addr(input int id, input int k);
    return 8'(((id - 1) * 4 + k) * 4);
  endfunction

  function automatic logic [31:0] exp_data(input logic [95:0] c, input int k);
    case (k)
      0:       return 32'(c >> 64);
      1:       return 32'((c >> 48) & 96'hFFFF);
      2:       return 32'((c >> 16) & 96'hFFFF_FFFF);
      default: return 32'(c & 96'hFFFF);
    endcase
  endfunction

  // Slave configuration and capture logs.
  int aw_lat = 0, w_lat = 0, b_lat = 0, err_k = 9;
  logic [7:0]  aw_q [$];
  logic [31:0] w_q [$];
  int b_cnt = 0, b_word = 0;

  bit aw_got, w_got, aw_fire, w_fire, b_fire;
  int aw_age, w_age, b_age;
  logic [7:0]  aw_hold;
  logic [31:0] w_hold;

  initial begin : slave
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        aw_got = 0; w_got = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
        aw_age = 0; w_age = 0; b_age = 0;
        continue;
      end
      if (aw_fire) begin awready = 0; aw_fire = 0; end
      if (w_fire)  begin wready = 0;  w_fire = 0;  end
      if (b_fire)  begin bvalid = 0; bresp = 2'b00; b_fire = 0; end
      if (aw_got && w_got && !bvalid) begin
        if (b_age >= b_lat) begin
          bvalid = 1;
          bresp  = (b_word == err_k) ? 2'b10 : 2'b00;
        end else b_age++;
      end
      if (bvalid && M_AXI_BREADY) begin
        b_fire = 1; b_cnt++; b_word++;
        aw_got = 0; w_got = 0; b_age = 0;
      end
      if (M_AXI_AWVALID && !aw_got) begin
        if (aw_age == 0) aw_hold = M_AXI_AWADDR;
        else chk("awaddr_stable", M_AXI_AWADDR, aw_hold);
        if (aw_age >= aw_lat) begin
          awready = 1; aw_fire = 1; aw_got = 1; aw_age = 0;
          aw_q.push_back(M_AXI_AWADDR);
          chk("awprot", M_AXI_AWPROT, 0);
        end else aw_age++;
      end
      if (M_AXI_WVALID && !w_got) begin
        if (w_age == 0) w_hold = M_AXI_WDATA;
        else chk("wdata_stable", M_AXI_WDATA, w_hold);
        if (w_age >= w_lat) begin
          wready = 1; w_fire = 1; w_got = 1; w_age = 0;
          w_q.push_back(M_AXI_WDATA);
          chk("wstrb", M_AXI_WSTRB, 4'hF);
        end else w_age++;
      end
    end
  end

  task automatic run_cmd(input string tag, input int id, input logic [95:0] cond,
                         input int awl, input int wl, input int bl, input int ek,
                         input bit chk_lat);
    bit legal;
    int acc, lat;
    legal = (id >= 1 && id <= 15);
    aw_lat = awl; w_lat = wl; b_lat = bl; err_k = ek;
    aw_q.delete(); w_q.delete(); b_cnt = 0; b_word = 0;
    @(negedge clk);
    tdata  = {8'(id), cond};
    tvalid = 1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      if (tready) begin acc = cyc; break; end
      @(negedge clk);
    end
    if (acc < 0) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      tvalid = 0;
      return;
    end
    lat = -1;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tvalid = 0;
        if (legal) chk({tag, "_busy"}, busy, 1);
      end
      if (resp_valid) begin lat = i; break; end
    end
    if (lat < 0) begin
      chk({tag, "_resp_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_resp_error"}, resp_error, (!legal || ek < 4) ? 1 : 0);
    if (chk_lat || !legal) chk({tag, "_latency"}, lat, legal ? 9 : 1);
    @(negedge clk);
    chk({tag, "_resp_pulse"}, resp_valid, 0);
    chk({tag, "_aw_count"}, aw_q.size(), legal ? 4 : 0);
    chk({tag, "_w_count"}, w_q.size(), legal ? 4 : 0);
    chk({tag, "_b_count"}, b_cnt, legal ? 4 : 0);
    for (int k = 0; k < 4 && k < aw_q.size() && k < w_q.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), aw_q[k], exp_addr(id, k));
      chk($sformatf("%s_data%0d", tag, k), w_q[k], exp_data(cond, k));
    end
    $display("cmd %s id=%0d cond=%h lat=%0d err=%0b writes=%0d", tag, id, cond, lat,
             resp_error, aw_q.size());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, tready, 0);
    chk({tag, "_awvalid"}, M_AXI_AWVALID, 0);
    chk({tag, "_wvalid"}, M_AXI_WVALID, 0);
    chk({tag, "_bready"}, M_AXI_BREADY, 0);
    chk({tag, "_resp"}, {resp_valid, resp_error, busy}, 0);
    chk({tag, "_awaddr"}, M_AXI_AWADDR, 0);
    chk({tag, "_wdata"}, M_AXI_WDATA, 0);
    chk({tag, "_wstrb"}, M_AXI_WSTRB, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [95:0] rc;
    bit hit;
    int id, awl, wl, bl, ek;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #2 rstn = 1;
    @(negedge clk);
    chk("tready_after_release", tready, 1);

    run_cmd("zero_wait", 1, {32'hC0A8_0102, 16'h0, 32'h0, 16'h0}, 0, 0, 0, 9, 1);
    run_cmd("id15_ones", 15, '1, 0, 0, 0, 9, 1);
    rc = {$urandom, $urandom, $urandom};
    run_cmd("slow_slave", 7, rc, 0, 3, 5, 9, 0);
    rc = {$urandom, $urandom, $urandom};
    run_cmd("bresp_k1", 3, rc, 0, 0, 0, 1, 1);
    run_cmd("id0", 0, rc, 0, 0, 0, 9, 1);
    run_cmd("id16", 16, rc, 0, 0, 0, 9, 1);

    // Reset while the third word is still in its address phase.
    aw_lat = 3; w_lat = 0; b_lat = 0; err_k = 9;
    aw_q.delete(); w_q.delete(); b_cnt = 0; b_word = 0;
    @(negedge clk);
    tdata = {8'd5, 32'h0A00_0001, 16'd80, 32'h0A00_0002, 16'd443};
    tvalid = 1;
    @(negedge clk);
    tvalid = 0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_cnt == 2 && M_AXI_AWVALID) begin hit = 1; break; end
    end
    chk("reset_reach_k2", hit, 1);
    #2 rstn = 0;
    #1 chk_reset_outputs("mid_reset");
    $display("reset asserted during k=2 address phase");
    repeat (3) @(negedge clk);
    #2 rstn = 1;
    @(negedge clk);
    chk("tready_after_mid_reset", tready, 1);
    run_cmd("after_reset", 9, {32'hDEAD_BEEF, 16'h1234, 32'h0102_0304, 16'hABCD}, 0, 0, 0, 9, 1);

    for (int n = 0; n < 20; n++) begin
      id  = $urandom_range(0, 17);
      rc  = {$urandom, $urandom, $urandom};
      awl = $urandom_range(0, 3);
      wl  = $urandom_range(0, 3);
      bl  = $urandom_range(0, 3);
      ek  = $urandom_range(0, 7);
      run_cmd($sformatf("rand%0d", n), id, rc, awl, wl, bl, ek,
              (awl == 0 && wl == 0 && bl == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
